pcie_io_mem_ram: RTL and testbench

Target-side memory for the PCIe I/O endpoint. It consumes the endpoint's memory request stream, stores write payloads into an on-chip 8 KB scratch RAM with byte strobes, and returns one response beat per written word and one data beat per 64-bit word read. Responses go back to the endpoint's completion path through a 2-entry response FIFO with valid/ready backpressure. The block sits directly downstream of the endpoint's memory request port.

---
 rtl/pcie_dma_pkg.sv | 16 +
 rtl/pcie_io_ram.sv | 35 +++
 rtl/pcie_io_mem_ram.sv | 127 ++++++++++++
 tb/tb_pcie_io_mem_ram.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared types and constants for the PCIe I/O endpoint memory target.
//   state_t         - request sequencer states (IDLE, READ)
//   RESP_FIFO_DEPTH - entries in the response FIFO
//   MEM_ABITS       - default byte address width of the scratch RAM
//   resp_beat_t     - one buffered response beat {last, fault, addr, data}
package pcie_dma_pkg;
   typedef enum logic {IDLE, READ} state_t;
   localparam int RESP_FIFO_DEPTH = 2;
   localparam int MEM_ABITS = 13;
   typedef struct packed {
      logic                 last;
      logic                 fault;
      logic [MEM_ABITS-1:0] addr;
      logic [63:0]          data;
   } resp_beat_t;
endpackage

// File: rtl/pcie_io_ram.sv
// pcie_io_ram: single-port synchronous RAM, 2^AW x 64, per-byte write enables,
// one-cycle read latency, write-first read-during-write.
//   i_clk   - clock
//   i_we    - byte write enables (bit b covers data[8b+7:8b])
//   i_addr  - word address
//   i_wdata - write data
//   o_rdata - read data, registered
module pcie_io_ram #(
   parameter int AW = 10
) (
   input  logic          i_clk,
   input  logic [7:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [63:0]   i_wdata,
   output logic [63:0]   o_rdata
);
   logic [63:0] r_mem [2**AW];
   logic [63:0] r_q;
   logic [63:0] w_merged;

   // Write-first: the read port returns the word as it looks after this cycle's write.
   always_comb begin
      w_merged = r_mem[i_addr];
      for (int b = 0; b < 8; b++)
         if (i_we[b]) w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 8; b++)
         if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      r_q <= w_merged;
   end

   assign o_rdata = r_q;
endmodule

// File: rtl/pcie_io_mem_ram.sv
// pcie_io_mem_ram: 8 KB scratch RAM target behind the PCIe I/O endpoint memory port.
// Writes update the RAM with byte strobes and return one response beat each;
// reads return one beat per 64-bit word touched, via a 2-entry response FIFO.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_req_mem_*         - request stream (valid/ready, write, bytes, addr, strob, data, last)
//   o_resp_mem_*        - response stream (valid/ready, last, fault, addr, data)
module pcie_io_mem_ram
   import pcie_dma_pkg::*;
#(
   parameter int ABITS = MEM_ABITS
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req_mem_valid,
   output logic             o_req_mem_ready,
   input  logic             i_req_mem_write,
   input  logic [9:0]       i_req_mem_bytes,
   input  logic [ABITS-1:0] i_req_mem_addr,
   input  logic [7:0]       i_req_mem_strob,
   input  logic [63:0]      i_req_mem_data,
   input  logic             i_req_mem_last,
   output logic             o_resp_mem_valid,
   input  logic             i_resp_mem_ready,
   output logic             o_resp_mem_last,
   output logic             o_resp_mem_fault,
   output logic [ABITS-1:0] o_resp_mem_addr,
   output logic [63:0]      o_resp_mem_data
);
   localparam int WA = ABITS - 3;
   localparam logic [ABITS:0] MEM_BYTES = (ABITS+1)'(1) << ABITS;

   state_t           r_state, w_state_nx;
   logic [ABITS-1:0] r_addr;
   logic [10:0]      r_n, r_k;
   logic             r_fault;
   logic             r_inf, r_inf_last, r_inf_fault;
   logic [ABITS-1:0] r_inf_addr;
   resp_beat_t       r_fifo [RESP_FIFO_DEPTH];
   logic             r_head;
   logic [1:0]       r_count;

   logic             w_pop, w_space, w_acc, w_wr, w_rd, w_issue, w_last, w_rd_fault, w_tail;
   logic [10:0]      w_beff, w_n;
   logic [ABITS:0]   w_end;
   logic [WA-1:0]    w_word, w_ram_addr;
   logic [ABITS-1:0] w_beat_addr;
   logic [7:0]       w_we;
   logic [63:0]      w_rdata;
   resp_beat_t       w_inf_beat, w_wr_beat, w_head;

   // Space accounts for the beat whose RAM read is still in flight, so an issue
   // or accept this cycle can never overflow the FIFO.
   assign w_pop   = o_resp_mem_valid & i_resp_mem_ready;
   assign w_space = ({1'b0, r_count} + {2'b0, r_inf} - {2'b0, w_pop}) < 3'(RESP_FIFO_DEPTH);
   assign o_req_mem_ready = !i_rst && r_state == IDLE && w_space;
   assign w_acc   = i_req_mem_valid & o_req_mem_ready;
   assign w_wr    = w_acc & i_req_mem_write;
   assign w_rd    = w_acc & !i_req_mem_write;
   assign w_issue = r_state == READ && w_space;

   assign w_beff     = i_req_mem_bytes == 10'd0 ? 11'd1024 : {1'b0, i_req_mem_bytes};
   assign w_n        = (11'(i_req_mem_addr[2:0]) + w_beff + 11'd7) >> 3;
   assign w_end      = {1'b0, i_req_mem_addr} + (ABITS+1)'(w_beff);
   assign w_rd_fault = w_end > MEM_BYTES;

   assign w_word      = r_addr[ABITS-1:3] + WA'(r_k);
   assign w_beat_addr = r_k == 11'd0 ? r_addr : {w_word, 3'b000};
   assign w_last      = r_k == r_n - 11'd1;

   assign w_ram_addr = w_issue ? w_word : i_req_mem_addr[ABITS-1:3];
   assign w_we       = w_wr ? i_req_mem_strob : 8'h00;

   pcie_io_ram #(.AW(WA)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (i_req_mem_data),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_nx = r_state;
      if (r_state == IDLE && w_rd) w_state_nx = READ;
      else if (w_issue && w_last) w_state_nx = IDLE;
   end

   // A read beat landing from RAM and a write accept can push in the same cycle
   // (first IDLE cycle after a read); the read beat is older and goes first.
   assign w_tail     = r_head + r_count[0];
   assign w_inf_beat = {r_inf_last, r_inf_fault, r_inf_addr, r_inf_fault ? 64'd0 : w_rdata};
   assign w_wr_beat  = {i_req_mem_last, 1'b0, i_req_mem_addr, 64'd0};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_inf   <= 1'b0;
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         r_inf   <= w_issue;
         if (w_issue) begin
            r_k         <= r_k + 11'd1;
            r_inf_last  <= w_last;
            r_inf_fault <= r_fault;
            r_inf_addr  <= w_beat_addr;
         end
         if (w_rd) begin
            r_addr  <= i_req_mem_addr;
            r_n     <= w_n;
            r_k     <= 11'd0;
            r_fault <= w_rd_fault;
         end
         if (r_inf) r_fifo[w_tail] <= w_inf_beat;
         if (w_wr) r_fifo[w_tail + r_inf] <= w_wr_beat;
         r_head  <= r_head + w_pop;
         r_count <= r_count + {1'b0, r_inf} + {1'b0, w_wr} - {1'b0, w_pop};
      end
   end

   assign w_head           = r_fifo[r_head];
   assign o_resp_mem_valid = !i_rst && r_count != 2'd0;
   assign o_resp_mem_last  = o_resp_mem_valid & w_head.last;
   assign o_resp_mem_fault = o_resp_mem_valid & w_head.fault;
   assign o_resp_mem_addr  = o_resp_mem_valid ? w_head.addr : '0;
   assign o_resp_mem_data  = o_resp_mem_valid ? w_head.data : '0;
endmodule

// File: tb/tb_pcie_io_mem_ram.sv
// tb_pcie_io_mem_ram: randomized bench for pcie_io_mem_ram with a word-array/queue reference model.
module tb_pcie_io_mem_ram;
   localparam int AB = 13;
   localparam int WORDS = 1024;

   logic          clk = 1'b0, rst = 1'b1;
   logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_last = 1'b0;
   logic [9:0]    req_bytes = '0;
   logic [AB-1:0] req_addr = '0;
   logic [7:0]    req_strob = '0;
   logic [63:0]   req_data = '0;
   logic          resp_valid, resp_ready = 1'b1, resp_last, resp_fault;
   logic [AB-1:0] resp_addr;
   logic [63:0]   resp_data;

   pcie_io_mem_ram #(.ABITS(AB)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req_mem_valid  (req_valid),
      .o_req_mem_ready  (req_ready),
      .i_req_mem_write  (req_write),
      .i_req_mem_bytes  (req_bytes),
      .i_req_mem_addr   (req_addr),
      .i_req_mem_strob  (req_strob),
      .i_req_mem_data   (req_data),
      .i_req_mem_last   (req_last),
      .o_resp_mem_valid (resp_valid),
      .i_resp_mem_ready (resp_ready),
      .o_resp_mem_last  (resp_last),
      .o_resp_mem_fault (resp_fault),
      .o_resp_mem_addr  (resp_addr),
      .o_resp_mem_data  (resp_data)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0, rdy_mode = 0;
   logic [63:0] mem_m [WORDS];
   logic [78:0] exp_q [$];
   int          pop_cyc [$];
   logic [63:0] last_data = '0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      resp_ready = rdy_mode == 0 ? 1'b1 :
                   rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) chk("spurious_valid", 80'(resp_valid), 80'd0);
         else begin
            chk("beat", {resp_last, resp_fault, resp_addr, resp_data}, exp_q.pop_front());
            pop_cyc.push_back(cyc);
            last_data = resp_data;
         end
      end
   end

   // Reference: writes merge into the word array; a read is expanded into its full
   // list of beats at accept time (no write can be accepted while a read is issuing).
   task automatic model_accept(input logic w, input logic [AB-1:0] a, input logic [9:0] b,
                               input logic [7:0] s, input logic [63:0] d, input logic l);
      int be, n, wd;
      logic f;
      logic [AB-1:0] ra;
      if (w) begin
         for (int i = 0; i < 8; i++) if (s[i]) mem_m[int'(a) / 8][i*8 +: 8] = d[i*8 +: 8];
         exp_q.push_back({l, 1'b0, a, 64'd0});
      end else begin
         be = b == 0 ? 1024 : int'(b);
         n  = (int'(a) % 8 + be + 7) / 8;
         f  = (int'(a) + be) > 8192;
         for (int k = 0; k < n; k++) begin
            wd = (int'(a) / 8 + k) % WORDS;
            ra = k == 0 ? a : AB'(wd * 8);
            exp_q.push_back({k == n - 1, f, ra, f ? 64'd0 : mem_m[wd]});
         end
      end
   endtask

   task automatic req(input logic w, input logic [AB-1:0] a, input logic [9:0] b,
                      input logic [7:0] s, input logic [63:0] d, input logic l);
      int t = 0;
      logic done = 1'b0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_bytes = b;
      req_strob = s; req_data = d; req_last = l;
      while (!done && t < 3000) begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(w, a, b, s, d, l);
            acc_cyc = cyc;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         t++;
      end
      if (!done) chk("req_timeout", 80'(req_ready), 80'd1);
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 80'(exp_q.size()), 80'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      int a0, first;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 80'(req_ready), 80'd0);
      chk("rst_valid", 80'(resp_valid), 80'd0);
      chk("rst_addr_data", {resp_addr, resp_data}, 80'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 80'(req_ready), 80'd1);
      @(posedge clk);
      #1;

      // Preload every word back-to-back; the accept cycles must be consecutive.
      for (int i = 0; i < WORDS; i++) begin
         req(1'b1, AB'(i * 8), 10'd0, 8'hFF, {$urandom, $urandom}, 1'(i));
         if (i == 0) first = acc_cyc;
      end
      idle();
      chk("b2b_writes", 80'(acc_cyc - first), 80'(WORDS - 1));
      drain();

      pop_cyc.delete();
      req(1'b1, 13'h010, 10'd0, 8'hFF, 64'h1122334455667788, 1'b1);
      a0 = acc_cyc;
      idle();
      drain();
      chk("wr_resp_count", 80'(pop_cyc.size()), 80'd1);
      chk("wr_latency", 80'(pop_cyc[0]), 80'(a0 + 1));

      req(1'b1, 13'h100, 10'd0, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
      req(1'b1, 13'h100, 10'd0, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1);
      req(1'b0, 13'h100, 10'd8, 8'h00, 64'd0, 1'b0);
      idle();
      drain();
      chk("strobe_merge", 80'(last_data), 80'h0000_FFFFFFFF_BBBBBBBB);

      pop_cyc.delete();
      req(1'b0, 13'h004, 10'd12, 8'h00, 64'd0, 1'b0);
      a0 = acc_cyc;
      idle();
      drain();
      chk("rd_beat_count", 80'(pop_cyc.size()), 80'd2);
      chk("rd_first_latency", 80'(pop_cyc[0]), 80'(a0 + 3));
      chk("rd_second_beat", 80'(pop_cyc[1]), 80'(a0 + 4));

      req(1'b0, 13'h1FF8, 10'd16, 8'h00, 64'd0, 1'b0);
      idle();
      drain();
      @(negedge clk);
      chk("fault_ready_back", 80'(req_ready), 80'd1);
      @(posedge clk);
      #1;

      rdy_mode = 1;
      pop_cyc.delete();
      req(1'b0, 13'h000, 10'd0, 8'h00, 64'd0, 1'b0);
      idle();
      drain();
      chk("burst_beat_count", 80'(pop_cyc.size()), 80'd128);
      rdy_mode = 0;

      req(1'b0, 13'h200, 10'd0, 8'h00, 64'd0, 1'b0);
      idle();
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrd_rst_ready", 80'(req_ready), 80'd0);
      chk("midrd_rst_valid", 80'(resp_valid), 80'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrd_post_ready", 80'(req_ready), 80'd1);
      repeat (10) @(posedge clk);
      #1;
      req(1'b0, 13'h200, 10'd24, 8'h00, 64'd0, 1'b0);
      idle();
      drain();

      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         req(1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0 ? AB'($urandom_range(8100, 8191)) : AB'($urandom_range(0, 1023)),
             $urandom_range(0, 20) == 0 ? 10'd0 : 10'($urandom_range(1, 40)),
             8'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
         end
      end
      idle();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
